// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package dcache_pkg;
    localparam int DC_LINES = 8;
    localparam int DC_WORDS = 4;
    localparam int DC_IDX_W = $clog2(DC_LINES);
    localparam int DC_TAG_W = 28 - DC_IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
endpackage

// File: rtl/dcache_lane_align.sv
// Combinational byte-lane logic: load extract/extend and store byte-merge on one 32-bit word.
module dcache_lane_align
    import dcache_pkg::*;
(
    input  logic [1:0]  byte_sel,
    input  logic [2:0]  funct3,
    input  logic [1:0]  size,
    input  logic [31:0] word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[8*byte_sel +: 8];
        lane_h = byte_sel[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   load_data = {{24{lane_b[7]}}, lane_b};
            F3_LH:   load_data = {{16{lane_h[15]}}, lane_h};
            F3_LW:   load_data = word;
            F3_LBU:  load_data = {24'h0, lane_b};
            F3_LHU:  load_data = {16'h0, lane_h};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        merged = word;
        case (size)
            SZ_B: merged[8*byte_sel +: 8] = store_data[7:0];
            SZ_H: begin
                if (byte_sel[1]) merged[31:16] = store_data[15:0];
                else             merged[15:0]  = store_data[15:0];
            end
            SZ_W:    merged = store_data;
            default: ;
        endcase
    end
endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate data cache with block-wide refill port.
// Define DCACHE_STATS_EN to add HIT_COUNT/MISS_COUNT outputs.
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int LINES = DC_LINES
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [3:0]   memReadEn,
    input  logic [2:0]   memWriteEn,
    input  logic [31:0]  DATA_CACHE_ADDR,
    input  logic [31:0]  DATA_CACHE_DATA,
    output logic [31:0]  DATA_CACHE_READ_DATA,
    output logic         DATA_CACHE_BUSY_WAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDR,
    output logic [127:0] MEM_WRITE_DATA,
    input  logic [127:0] MEM_READ_DATA,
    input  logic         MEM_BUSY_WAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  HIT_COUNT,
    output logic [31:0]  MISS_COUNT
`endif
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 28 - IDX_W;

    logic             rd_req, wr_req, req, hit, done;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       wsel;
    logic [31:0]      cur_word, load_data, merged;

    logic [LINES-1:0] valid, dirty;
    logic [TAG_W-1:0] tags   [LINES];
    logic [127:0]     blocks [LINES];

    state_t state, next_state;

    assign rd_req   = memReadEn[3];
    assign wr_req   = memWriteEn[2];
    assign req      = rd_req | wr_req;
    assign wsel     = DATA_CACHE_ADDR[3:2];
    assign idx      = DATA_CACHE_ADDR[IDX_W+3:4];
    assign tag      = DATA_CACHE_ADDR[31:IDX_W+4];
    assign hit      = valid[idx] && (tags[idx] == tag);
    assign cur_word = blocks[idx][32*wsel +: 32];
    assign done     = !MEM_BUSY_WAIT;

    dcache_lane_align u_align (
        .byte_sel   (DATA_CACHE_ADDR[1:0]),
        .funct3     (memReadEn[2:0]),
        .size       (memWriteEn[1:0]),
        .word       (cur_word),
        .store_data (DATA_CACHE_DATA),
        .load_data  (load_data),
        .merged     (merged)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (req && !hit) next_state = dirty[idx] ? S_WRITEBACK : S_ALLOCATE;
            S_WRITEBACK: if (done) next_state = S_ALLOCATE;
            S_ALLOCATE:  if (done) next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    // RESET gates the CPU-facing outputs so they drop while reset is held, even with a request present.
    always_comb begin
        MEM_READ             = (state == S_ALLOCATE);
        MEM_WRITE            = (state == S_WRITEBACK);
        MEM_ADDR             = '0;
        MEM_WRITE_DATA       = '0;
        if (state == S_WRITEBACK) begin
            MEM_ADDR       = {tags[idx], idx};
            MEM_WRITE_DATA = blocks[idx];
        end else if (state == S_ALLOCATE) begin
            MEM_ADDR       = {tag, idx};
        end
        DATA_CACHE_BUSY_WAIT = RESET && ((state != S_IDLE) || (req && !hit));
        DATA_CACHE_READ_DATA = (RESET && rd_req) ? load_data : '0;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid <= '0;
            dirty <= '0;
        end else if (state == S_ALLOCATE && done) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (state == S_IDLE && wr_req && hit) begin
            dirty[idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (state == S_ALLOCATE && done) begin
            tags[idx]   <= tag;
            blocks[idx] <= MEM_READ_DATA;
        end else if (state == S_IDLE && wr_req && hit) begin
            blocks[idx][32*wsel +: 32] <= merged;
        end
    end

`ifdef DCACHE_STATS_EN
    // The hit that completes a refilled access belongs to the miss already counted.
    logic retry_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            retry_q    <= 1'b0;
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else begin
            retry_q <= (state == S_ALLOCATE) && done;
            if (state == S_IDLE && req) begin
                if (!hit)          MISS_COUNT <= MISS_COUNT + 32'd1;
                else if (!retry_q) HIT_COUNT  <= HIT_COUNT + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder with a small fixed-latency block memory model.
module tb_dcache_responder;
    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [3:0]   memReadEn = '0;
    logic [2:0]   memWriteEn = '0;
    logic [31:0]  DATA_CACHE_ADDR = '0;
    logic [31:0]  DATA_CACHE_DATA = '0;
    logic [31:0]  DATA_CACHE_READ_DATA;
    logic         DATA_CACHE_BUSY_WAIT;
    logic         MEM_READ, MEM_WRITE;
    logic [27:0]  MEM_ADDR;
    logic [127:0] MEM_WRITE_DATA;
    logic [127:0] MEM_READ_DATA;
    logic         MEM_BUSY_WAIT;
`ifdef DCACHE_STATS_EN
    logic [31:0]  HIT_COUNT, MISS_COUNT;
`endif

    int errors = 0;
    int checks = 0;

    dcache_responder dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .memReadEn            (memReadEn),
        .memWriteEn           (memWriteEn),
        .DATA_CACHE_ADDR      (DATA_CACHE_ADDR),
        .DATA_CACHE_DATA      (DATA_CACHE_DATA),
        .DATA_CACHE_READ_DATA (DATA_CACHE_READ_DATA),
        .DATA_CACHE_BUSY_WAIT (DATA_CACHE_BUSY_WAIT),
        .MEM_READ             (MEM_READ),
        .MEM_WRITE            (MEM_WRITE),
        .MEM_ADDR             (MEM_ADDR),
        .MEM_WRITE_DATA       (MEM_WRITE_DATA),
        .MEM_READ_DATA        (MEM_READ_DATA),
        .MEM_BUSY_WAIT        (MEM_BUSY_WAIT)
`ifdef DCACHE_STATS_EN
        ,
        .HIT_COUNT            (HIT_COUNT),
        .MISS_COUNT           (MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory: busy for 3 cycles after each new request, then completes.
    int           mcnt = 0;
    logic         wb_seen = 1'b0;
    logic [27:0]  wb_addr = '0;
    logic [127:0] wb_data = '0;

    function automatic logic [127:0] init_blk(input logic [27:0] a);
        case (a)
            28'h1:   return 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_11223344;
            28'h9:   return 128'h0000000F_0000000E_0000000D_99990000;
            default: return '0;
        endcase
    endfunction

    assign MEM_BUSY_WAIT = (MEM_READ || MEM_WRITE) && (mcnt != 3);
    assign MEM_READ_DATA = (wb_seen && MEM_ADDR == wb_addr) ? wb_data : init_blk(MEM_ADDR);

    always @(posedge CLK) begin
        if (!(MEM_READ || MEM_WRITE) || !MEM_BUSY_WAIT) mcnt <= 0;
        else                                            mcnt <= mcnt + 1;
        if (MEM_WRITE && !MEM_BUSY_WAIT) begin
            wb_seen <= 1'b1;
            wb_addr <= MEM_ADDR;
            wb_data <= MEM_WRITE_DATA;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!DATA_CACHE_BUSY_WAIT) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, ok, 1'b1);
    endtask

    task automatic wait_mem_read(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (MEM_READ) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, ok, 1'b1);
    endtask

    task automatic cpu(input logic [3:0] re, input logic [2:0] we,
                       input logic [31:0] a, input logic [31:0] d);
        memReadEn = re;
        memWriteEn = we;
        DATA_CACHE_ADDR = a;
        DATA_CACHE_DATA = d;
        #1;
    endtask

    initial begin
        step();
        step();
        chk("rst_busy", DATA_CACHE_BUSY_WAIT, 1'b0);
        chk("rst_mem_read", MEM_READ, 1'b0);
        chk("rst_mem_write", MEM_WRITE, 1'b0);
        cpu(4'b1010, 3'b000, 32'h10, 32'h0);
        chk("rst_rdata_gated", DATA_CACHE_READ_DATA, 32'h0);
        chk("rst_busy_gated", DATA_CACHE_BUSY_WAIT, 1'b0);
        RESET = 1'b1;
        #1;

        // Cold miss on LW 0x10
        chk("cold_busy_same_cycle", DATA_CACHE_BUSY_WAIT, 1'b1);
        step();
        chk("cold_mem_read", MEM_READ, 1'b1);
        chk("cold_mem_addr", MEM_ADDR, 28'h1);
        chk("cold_mem_write", MEM_WRITE, 1'b0);
        wait_ready("cold_ready_timeout");
        chk("cold_rdata", DATA_CACHE_READ_DATA, 32'h11223344);
        chk("cold_mem_read_drop", MEM_READ, 1'b0);
        step();

        // Store hit then loads
        cpu(4'b0000, 3'b100, 32'h13, 32'h123456A5);
        chk("sb_no_stall", DATA_CACHE_BUSY_WAIT, 1'b0);
        step();
        cpu(4'b1000, 3'b000, 32'h13, 32'h0);
        chk("lb_13", DATA_CACHE_READ_DATA, 32'hFFFFFFA5);
        chk("lb_no_stall", DATA_CACHE_BUSY_WAIT, 1'b0);
        cpu(4'b1100, 3'b000, 32'h13, 32'h0);
        chk("lbu_13", DATA_CACHE_READ_DATA, 32'h000000A5);
        cpu(4'b1010, 3'b000, 32'h10, 32'h0);
        chk("lw_10", DATA_CACHE_READ_DATA, 32'hA5223344);
        cpu(4'b1001, 3'b000, 32'h12, 32'h0);
        chk("lh_12", DATA_CACHE_READ_DATA, 32'hFFFFA522);
        cpu(4'b1101, 3'b000, 32'h12, 32'h0);
        chk("lhu_12", DATA_CACHE_READ_DATA, 32'h0000A522);
        cpu(4'b1000, 3'b000, 32'h14, 32'h0);
        chk("lb_14", DATA_CACHE_READ_DATA, 32'hFFFFFFBB);
        cpu(4'b0000, 3'b000, 32'h10, 32'h0);
        chk("no_req_rdata_zero", DATA_CACHE_READ_DATA, 32'h0);

        // Dirty eviction: LW 0x90 conflicts with line holding 0x10
        cpu(4'b1010, 3'b000, 32'h90, 32'h0);
        chk("evict_busy", DATA_CACHE_BUSY_WAIT, 1'b1);
        step();
        chk("wb_mem_write", MEM_WRITE, 1'b1);
        chk("wb_mem_read", MEM_READ, 1'b0);
        chk("wb_mem_addr", MEM_ADDR, 28'h1);
        chk("wb_word0", MEM_WRITE_DATA[31:0], 32'hA5223344);
        chk("wb_word1", MEM_WRITE_DATA[63:32], 32'hBBBBBBBB);
        wait_mem_read("wb_to_alloc_timeout");
        chk("alloc_mem_addr", MEM_ADDR, 28'h9);
        chk("alloc_mem_write_drop", MEM_WRITE, 1'b0);
        wait_ready("evict_ready_timeout");
        chk("evict_rdata", DATA_CACHE_READ_DATA, 32'h99990000);
        chk("wb_captured", wb_data[31:0], 32'hA5223344);
        step();

        // Refilled line is clean: conflicting miss goes straight to ALLOCATE
        cpu(4'b1010, 3'b000, 32'h10, 32'h0);
        step();
        chk("clean_no_wb", MEM_WRITE, 1'b0);
        chk("clean_alloc", MEM_READ, 1'b1);
        chk("clean_alloc_addr", MEM_ADDR, 28'h1);

        // Reset mid-ALLOCATE
        RESET = 1'b0;
        #1;
        chk("abort_mem_read", MEM_READ, 1'b0);
        chk("abort_busy", DATA_CACHE_BUSY_WAIT, 1'b0);
        chk("abort_rdata", DATA_CACHE_READ_DATA, 32'h0);
        step();
        step();
        RESET = 1'b1;
        #1;
        chk("post_abort_miss", DATA_CACHE_BUSY_WAIT, 1'b1);
        wait_ready("post_abort_timeout");
        chk("post_abort_rdata", DATA_CACHE_READ_DATA, 32'hA5223344);
        step();

`ifdef DCACHE_STATS_EN
        cpu(4'b0000, 3'b000, 32'h0, 32'h0);
        RESET = 1'b0;
        #1;
        chk("stats_rst_hit", HIT_COUNT, 32'd0);
        chk("stats_rst_miss", MISS_COUNT, 32'd0);
        step();
        RESET = 1'b1;
        cpu(4'b1010, 3'b000, 32'h10, 32'h0);
        wait_ready("stats_miss1_timeout");
        step();
        cpu(4'b1010, 3'b000, 32'h14, 32'h0);
        step();
        cpu(4'b1010, 3'b000, 32'h18, 32'h0);
        step();
        cpu(4'b1100, 3'b000, 32'h11, 32'h0);
        step();
        cpu(4'b1010, 3'b000, 32'h90, 32'h0);
        wait_ready("stats_miss2_timeout");
        step();
        cpu(4'b0000, 3'b000, 32'h0, 32'h0);
        step();
        chk("stats_hit", HIT_COUNT, 32'd3);
        chk("stats_miss", MISS_COUNT, 32'd2);
        RESET = 1'b0;
        #1;
        chk("stats_clr_hit", HIT_COUNT, 32'd0);
        chk("stats_clr_miss", MISS_COUNT, 32'd0);
        RESET = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dcache_responder.md
# dcache_responder

Direct-mapped, write-back, write-allocate data cache that terminates the CPU's data-memory port (memReadEn/memWriteEn/address/write-data in; read data and busy-wait out) and refills from main memory over a block-wide busy-wait port. Hits complete with zero stall; misses hold DATA_CACHE_BUSY_WAIT high until the line is written back and refilled. It sits between the pipelined RV32IM core's memory stage and the main data memory.

## Interface
- LINES, 8, number of cache lines (power of two)
- WORDS, 4, 32-bit words per block (fixed 4 in this revision; 128-bit memory bus)
- CLK  in  1  clock; all state on rising edge
- RESET  in  1  asynchronous, active-low reset
- memReadEn  in  4  bit3 = read request; bits[2:0] = RV32 funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- memWriteEn  in  3  bit2 = write request; bits[1:0] = size (00 SB, 01 SH, 10 SW)
- DATA_CACHE_ADDR  in  32  byte address
- DATA_CACHE_DATA  in  32  store data, right-aligned
- DATA_CACHE_READ_DATA  out  32  extended load result
- DATA_CACHE_BUSY_WAIT  out  1  CPU stall
- MEM_READ  out  1  block read request
- MEM_WRITE  out  1  block write request
- MEM_ADDR  out  28  block address (byte address >> 4)
- MEM_WRITE_DATA  out  128  evicted block, word0 in [31:0]
- MEM_READ_DATA  in  128  refill block, word0 in [31:0]
- MEM_BUSY_WAIT  in  1  memory stall

## Operation
- Address split: [1:0] byte, [3:2] word, [log2(LINES)+3:4] index, remainder tag.
- Per line: valid, dirty, tag, 128-bit data. Tag compare and read mux are combinational.
- Request = memReadEn[3] | memWriteEn[2]. Both set: treated as write; read data still driven.
- FSM states IDLE, WRITEBACK, ALLOCATE.
  - IDLE, request, hit: no stall. On store, merge the bytes on the posedge and set dirty.
  - IDLE, request, miss, dirty: go to WRITEBACK.
  - IDLE, request, miss, clean: go to ALLOCATE.
  - WRITEBACK: MEM_WRITE=1, MEM_ADDR={old tag,index}, MEM_WRITE_DATA=line. A posedge with MEM_BUSY_WAIT=0 completes the transfer; go to ALLOCATE.
  - ALLOCATE: MEM_READ=1, MEM_ADDR={new tag,index}. A posedge with MEM_BUSY_WAIT=0 loads MEM_READ_DATA and sets valid=1, dirty=0, tag; go to IDLE.
- DATA_CACHE_BUSY_WAIT = (state≠IDLE) | (request & ~hit). Combinational, so it rises in the same cycle as a missing request.
- Loads:
  - LB/LBU select lane addr[1:0].
  - LH/LHU select the half at addr[1]; addr[0] is ignored.
  - LW ignores addr[1:0].
  - Sign- or zero-extend per funct3.
  - Output is 0 when no read request is present.
- Stores use the same lane rules. Only the addressed bytes change.
- The CPU holds its request stable while busy is high. It samples read data on the first posedge with busy low.

## Timing
- Hit: 0 stall cycles, load data valid in the request cycle.
- Clean miss: stall = memory read latency + 1. Dirty miss: adds the write latency.
- Memory must raise MEM_BUSY_WAIT combinationally on a new request. MEM_READ/MEM_WRITE drop in the cycle after completion.
- Reset (RESET=0, any time):
  - Clears all valid/dirty bits; state=IDLE.
  - Outputs go to 0 immediately, including in-flight MEM_READ/MEM_WRITE, DATA_CACHE_BUSY_WAIT and DATA_CACHE_READ_DATA.
  - An aborted transfer is discarded; the line stays invalid.
- Index wrap: any two addresses with equal index and different tag conflict. There is no replacement choice.

## Configuration
- DCACHE_STATS_EN defined: adds outputs HIT_COUNT[31:0] and MISS_COUNT[31:0].
  - Each increments once per completed CPU access: a hit in IDLE, or a miss counted on entering WRITEBACK/ALLOCATE.
  - Both clear on reset and wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package dcache_pkg holds the state enum, funct3 load codes, store size codes, and the field-width constants derived from LINES.
- Sub-module dcache_lane_align is combinational. It does load extraction/extension and store byte-merge into a 32-bit word.
- Tag/valid/dirty/data arrays and the FSM stay in dcache_responder.

## Test plan
- Cold miss: after reset, LW 0x10.
  - Busy rises the same cycle; MEM_READ=1 with MEM_ADDR=0x1.
  - Memory returns 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_11223344 after 3 busy cycles.
  - Busy drops; read data = 0x11223344.
- Store hit, then loads: SB 0xA5 to 0x13 has no stall.
  - LB 0x13 returns 0xFFFFFFA5; LBU 0x13 returns 0x000000A5; LW 0x10 returns 0xA5223344.
- Half loads: LH 0x12 returns 0xFFFFA522; LHU 0x12 returns 0x0000A522.
- Dirty eviction: after the store above, LW 0x90 (same index, new tag).
  - MEM_WRITE first, with MEM_ADDR=0x1 and word0=0xA5223344.
  - Then MEM_READ with MEM_ADDR=0x9. Dirty is clear after the refill.
- Reset mid-ALLOCATE: assert RESET=0 during a MEM_READ.
  - MEM_READ and busy drop asynchronously.
  - A later LW 0x10 misses again.
- With DCACHE_STATS_EN: run 3 hits and 2 misses → HIT_COUNT=3, MISS_COUNT=2. After reset both are 0.
